serial_alu_ctrl: RTL

SERIAL_ALU_CTRL -- requirements
Module: serial_alu_ctrl

---
 rtl/serial_alu_ctrl_if.sv | 26 ++
 rtl/serial_alu_ctrl.sv | 108 ++++++++++
 2 files changed

// File: rtl/serial_alu_ctrl_if.sv
// Handshake/operand bundle for the bit-serial ALU controller.
// The master issues start/op/operands; the slave returns status and result.
interface serial_alu_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             zero;

  modport master (
    output start, op, a, b, cin,
    input  busy, done, result, cout, zero
  );

  modport slave (
    input  start, op, a, b, cin,
    output busy, done, result, cout, zero
  );
endinterface

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU controller: one 1-bit slice processes the operands LSB first,
// one bit per clock, with an IDLE -> RUN -> DONE sequencer around it.
module serial_alu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_alu_ctrl_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] result_reg;
  logic [1:0]       op_reg;
  logic             carry_reg;
  logic             cout_reg;
  logic [CW-1:0]    cnt_reg;

  logic             slice_bit;
  logic             slice_carry;
  logic             last_bit;

  assign last_bit = (cnt_reg == CW'(WIDTH - 1));

  // The single 1-bit slice; carry only propagates for add.
  always_comb begin
    slice_bit   = 1'b0;
    slice_carry = 1'b0;
    case (op_reg)
      2'b00:   {slice_carry, slice_bit} = {1'b0, a_reg[0]} + {1'b0, b_reg[0]} + {1'b0, carry_reg};
      2'b01:   slice_bit = a_reg[0] & b_reg[0];
      2'b10:   slice_bit = ~(a_reg[0] | b_reg[0]);
      default: slice_bit = a_reg[0] ^ b_reg[0];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last_bit)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= 2'b00;
      carry_reg  <= 1'b0;
      cnt_reg    <= '0;
      result_reg <= '0;
      cout_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            a_reg      <= bus.a;
            b_reg      <= bus.b;
            op_reg     <= bus.op;
            carry_reg  <= bus.cin;
            cnt_reg    <= '0;
            result_reg <= '0;
            cout_reg   <= 1'b0;
          end
        end
        RUN: begin
          result_reg[cnt_reg] <= slice_bit;
          carry_reg           <= slice_carry;
          a_reg               <= a_reg >> 1;
          b_reg               <= b_reg >> 1;
          // Counter parks on the last index instead of wrapping.
          if (last_bit) begin
            cout_reg <= slice_carry;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state_reg == RUN);
  assign bus.done   = (state_reg == DONE);
  assign bus.result = result_reg;
  assign bus.cout   = cout_reg;
  assign bus.zero   = (result_reg == '0);
endmodule
